// File: rtl/gtech_reduce_pipe.sv
// Pipelined N-lane bitwise AND/OR/XOR reducer built as a K-ary tree of elastic stages.
// Optional output-transfer counter port CNT when GTECH_REDUCE_PIPE_CNT_EN is defined.
module gtech_reduce_pipe #(
    parameter int N = 8,
    parameter int W = 4,
    parameter int K = 3
) (
    input  logic           CP,
    input  logic           CD,
    input  logic [N*W-1:0] A,
    input  logic [1:0]     MODE,
    input  logic           INV,
    input  logic           IN_VLD,
    output logic           IN_RDY,
    output logic [W-1:0]   Z,
    output logic           OUT_VLD,
    input  logic           OUT_RDY
`ifdef GTECH_REDUCE_PIPE_CNT_EN
    ,
    output logic [15:0]    CNT
`endif
);

    function automatic int calc_stages(input int n, input int k);
        int s;
        int c;
        s = 0;
        c = 1;
        while (c < n) begin
            c = c * k;
            s = s + 1;
        end
        return s;
    endfunction

    function automatic int lanes_at(input int n, input int k, input int s);
        int r;
        r = n;
        for (int i = 0; i < s; i++) begin
            r = (r + k - 1) / k;
        end
        return r;
    endfunction

    localparam int STAGES = calc_stages(N, K);

    function automatic logic [W-1:0] ident(input logic [1:0] m);
        case (m)
            2'b01, 2'b10: ident = {W{1'b0}};
            default:      ident = {W{1'b1}};
        endcase
    endfunction

    function automatic logic [W-1:0] red_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] m);
        case (m)
            2'b01:   red_op = a | b;
            2'b10:   red_op = a ^ b;
            default: red_op = a & b;
        endcase
    endfunction

    logic [STAGES-1:0] vld_r;
    logic [STAGES-1:0] en_s;

    // Backpressure chain: a stage may load when it is empty or its successor moves.
    always_comb begin
        en_s = {STAGES{1'b0}};
        en_s[STAGES-1] = !vld_r[STAGES-1] || OUT_RDY;
        for (int s = STAGES - 2; s >= 0; s--) begin
            en_s[s] = !vld_r[s] || en_s[s+1];
        end
    end

    // Stage valid bits; bubbles are shifted in like beats so they collapse under stall.
    always_ff @(posedge CP) begin
        if (!CD) begin
            vld_r <= {STAGES{1'b0}};
        end else begin
            if (en_s[0]) begin
                vld_r[0] <= IN_VLD;
            end
            for (int s = 1; s < STAGES; s++) begin
                if (en_s[s]) begin
                    vld_r[s] <= vld_r[s-1];
                end
            end
        end
    end

    assign IN_RDY  = en_s[0];
    assign OUT_VLD = vld_r[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int NI = lanes_at(N, K, k);
        localparam int NO = lanes_at(N, K, k + 1);

        logic [NI*W-1:0] din_s;
        logic [1:0]      mode_in_s;
        logic            inv_in_s;
        logic            vin_s;
        logic            load_s;
        logic [NO*W-1:0] comb_s;

        if (k == 0) begin : g_src
            assign din_s     = A;
            assign mode_in_s = MODE;
            assign inv_in_s  = INV;
            assign vin_s     = IN_VLD;
        end else begin : g_src
            assign din_s     = g_stg[k-1].g_reg.data_r;
            assign mode_in_s = g_stg[k-1].g_reg.mode_r;
            assign inv_in_s  = g_stg[k-1].g_reg.inv_r;
            assign vin_s     = vld_r[k-1];
        end

        assign load_s = en_s[k] && vin_s;

        // Group reduction; a short last group is filled with the operation's identity.
        always_comb begin
            logic [W-1:0] acc_s;
            int           idx_s;
            comb_s = {(NO*W){1'b0}};
            for (int j = 0; j < NO; j++) begin
                acc_s = ident(mode_in_s);
                for (int i = 0; i < K; i++) begin
                    idx_s = ((j * K + i) < NI) ? (j * K + i) : 0;
                    if ((j * K + i) < NI) begin
                        acc_s = red_op(acc_s, din_s[idx_s*W +: W], mode_in_s);
                    end else begin
                        acc_s = red_op(acc_s, ident(mode_in_s), mode_in_s);
                    end
                end
                comb_s[j*W +: W] = acc_s;
            end
        end

        if (k == STAGES - 1) begin : g_reg
            logic [W-1:0] z_r;

            // Final stage: inversion applied once, result held while downstream stalls.
            always_ff @(posedge CP) begin
                if (!CD) begin
                    z_r <= {W{1'b0}};
                end else if (load_s) begin
                    z_r <= comb_s[W-1:0] ^ {W{inv_in_s}};
                end
            end

            assign Z = z_r;
        end else begin : g_reg
            logic [NO*W-1:0] data_r;
            logic [1:0]      mode_r;
            logic            inv_r;

            // Intermediate stage: partial results plus the beat's sideband.
            always_ff @(posedge CP) begin
                if (!CD) begin
                    data_r <= {(NO*W){1'b0}};
                    mode_r <= 2'b00;
                    inv_r  <= 1'b0;
                end else if (load_s) begin
                    data_r <= comb_s;
                    mode_r <= mode_in_s;
                    inv_r  <= inv_in_s;
                end
            end
        end
    end

`ifdef GTECH_REDUCE_PIPE_CNT_EN
    logic [15:0] cnt_r;

    // Saturating count of output transfers.
    always_ff @(posedge CP) begin
        if (!CD) begin
            cnt_r <= 16'h0000;
        end else if (OUT_VLD && OUT_RDY && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'h0001;
        end
    end

    assign CNT = cnt_r;
`endif

endmodule

// File: tb/tb_gtech_reduce_pipe.sv
// Self-checking bench for gtech_reduce_pipe: vector table, scoreboard, stall and reset sequences.
module tb_gtech_reduce_pipe;
    localparam int N = 8;
    localparam int W = 4;

    logic           CP = 1'b0;
    logic           CD;
    logic [N*W-1:0] A;
    logic [1:0]     MODE;
    logic           INV;
    logic           IN_VLD;
    logic           IN_RDY;
    logic [W-1:0]   Z;
    logic           OUT_VLD;
    logic           OUT_RDY;
`ifdef GTECH_REDUCE_PIPE_CNT_EN
    logic [15:0]    CNT;
`endif

    gtech_reduce_pipe #(.N(N), .W(W), .K(3)) dut (
        .CP(CP), .CD(CD), .A(A), .MODE(MODE), .INV(INV),
        .IN_VLD(IN_VLD), .IN_RDY(IN_RDY), .Z(Z), .OUT_VLD(OUT_VLD), .OUT_RDY(OUT_RDY)
`ifdef GTECH_REDUCE_PIPE_CNT_EN
        , .CNT(CNT)
`endif
    );

    always #5 CP = ~CP;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb[$];

    typedef struct {
        logic [N*W-1:0] a;
        logic [1:0]     mode;
        logic           inv;
        logic [W-1:0]   z;
        string          name;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [N*W-1:0] a, input logic [1:0] m, input logic i,
                                input logic [W-1:0] z, input string n);
        vec_t v;
        v.a = a;
        v.mode = m;
        v.inv = i;
        v.z = z;
        v.name = n;
        return v;
    endfunction

    // Flat reduction over all lanes, independent of tree shape.
    function automatic logic [W-1:0] model(input logic [N*W-1:0] a, input logic [1:0] m,
                                           input logic inv);
        logic [W-1:0] acc;
        acc = a[W-1:0];
        for (int i = 1; i < N; i++) begin
            case (m)
                2'b01:   acc = acc | a[i*W +: W];
                2'b10:   acc = acc ^ a[i*W +: W];
                default: acc = acc & a[i*W +: W];
            endcase
        end
        return inv ? ~acc : acc;
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge CP) begin
        if (!CD) begin
            sb.delete();
        end else begin
            if (OUT_VLD && OUT_RDY) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    chk("sb_z", 32'(Z), 32'(sb.pop_front()));
                end
            end
            if (IN_VLD && IN_RDY) begin
                sb.push_back(model(A, MODE, INV));
            end
        end
    end

    initial begin
        int b;
        int outs;
        int gaps;
        int unstable;
        int stale;
        int got;
        bit have;
        logic [W-1:0] zh;
        logic [W-1:0] mexp[3];

        vecs[0] = mk(32'hFFFF_FFFF, 2'b00, 1'b0, 4'hF, "and_all_f");
        vecs[1] = mk(32'hFFFF_EFFF, 2'b00, 1'b0, 4'hE, "and_lane3_e");
        vecs[2] = mk(32'h0003_8421, 2'b10, 1'b0, 4'hC, "xor");
        vecs[3] = mk(32'h0003_8421, 2'b10, 1'b1, 4'h3, "xnor");
        vecs[4] = mk(32'h5000_0000, 2'b01, 1'b0, 4'h5, "or_short_group");
        vecs[5] = mk(32'h0FFF_FFFF, 2'b00, 1'b0, 4'h0, "and_short_group");
        vecs[6] = mk(32'hFFFF_EFFF, 2'b11, 1'b0, 4'hE, "and_alias");
        vecs[7] = mk(32'h0000_0000, 2'b01, 1'b1, 4'hF, "nor_zero");
        vecs[8] = mk(32'hFFFF_FFFF, 2'b00, 1'b1, 4'h0, "nand_all_f");
        mexp[0] = 4'h6;
        mexp[1] = 4'hE;
        mexp[2] = 4'h8;

        CD = 1'b0; A = 32'h0; MODE = 2'b00; INV = 1'b0; IN_VLD = 1'b0; OUT_RDY = 1'b1;
        @(posedge CP);
        @(posedge CP);
        @(negedge CP);
        chk("rst_out_vld", 32'(OUT_VLD), 32'd0);
        chk("rst_z", 32'(Z), 32'd0);
        @(posedge CP); #1;
        CD = 1'b1;
        @(negedge CP);
        chk("rst_in_rdy", 32'(IN_RDY), 32'd1);
`ifdef GTECH_REDUCE_PIPE_CNT_EN
        chk("rst_cnt", 32'(CNT), 32'd0);
`endif

        // Single beats: exact two-cycle latency and expected result.
        for (int i = 0; i < 9; i++) begin
            @(posedge CP); #1;
            A = vecs[i].a; MODE = vecs[i].mode; INV = vecs[i].inv; IN_VLD = 1'b1;
            @(negedge CP);
            chk({vecs[i].name, "_in_rdy"}, 32'(IN_RDY), 32'd1);
            @(posedge CP); #1;
            IN_VLD = 1'b0;
            @(negedge CP);
            chk({vecs[i].name, "_lat1"}, 32'(OUT_VLD), 32'd0);
            @(posedge CP);
            @(negedge CP);
            chk({vecs[i].name, "_lat2"}, 32'(OUT_VLD), 32'd1);
            chk({vecs[i].name, "_z"}, 32'(Z), 32'(vecs[i].z));
        end

        // Backpressure: five beats offered while downstream stalls.
        b = 0; have = 1'b0; unstable = 0; zh = 4'h0;
        for (int c = 0; c < 6; c++) begin
            @(posedge CP); #1;
            OUT_RDY = 1'b0; A = 32'(b + 1); MODE = 2'b01; INV = 1'b0; IN_VLD = 1'b1;
            @(negedge CP);
            if (IN_RDY) b++;
            if (OUT_VLD) begin
                if (!have) begin
                    zh = Z;
                    have = 1'b1;
                end else if (Z !== zh) begin
                    unstable++;
                end
            end
        end
        chk("bp_accepted", 32'(b), 32'd2);
        chk("bp_in_rdy_low", 32'(IN_RDY), 32'd0);
        chk("bp_out_vld_held", 32'(OUT_VLD), 32'd1);
        chk("bp_z_stable", 32'(unstable), 32'd0);
        chk("bp_z_first", 32'(zh), 32'd1);

        outs = 0; gaps = 0;
        for (int c = 0; c < 20 && outs < 5; c++) begin
            @(posedge CP); #1;
            OUT_RDY = 1'b1; A = 32'(b + 1); IN_VLD = (b < 5);
            @(negedge CP);
            if (IN_VLD && IN_RDY) b++;
            if (OUT_VLD) begin
                chk("bp_order", 32'(Z), 32'(outs + 1));
                outs++;
            end else if (outs > 0) begin
                gaps++;
            end
        end
        @(posedge CP); #1;
        IN_VLD = 1'b0;
        chk("bp_out_count", 32'(outs), 32'd5);
        chk("bp_gaps", 32'(gaps), 32'd0);

        // Reset with two beats in flight.
        @(posedge CP); #1;
        OUT_RDY = 1'b0; A = 32'h1111_1111; MODE = 2'b00; INV = 1'b0; IN_VLD = 1'b1;
        @(posedge CP); #1;
        A = 32'h2222_2222;
        @(posedge CP); #1;
        IN_VLD = 1'b0; CD = 1'b0;
        @(posedge CP); #1;
        CD = 1'b1;
        @(negedge CP);
        chk("mid_rst_out_vld", 32'(OUT_VLD), 32'd0);
        chk("mid_rst_z", 32'(Z), 32'd0);
        chk("mid_rst_in_rdy", 32'(IN_RDY), 32'd1);
`ifdef GTECH_REDUCE_PIPE_CNT_EN
        chk("mid_rst_cnt", 32'(CNT), 32'd0);
`endif
        OUT_RDY = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CP);
            if (OUT_VLD) stale++;
        end
        chk("mid_rst_no_stale", 32'(stale), 32'd0);

        // Per-beat mode on identical lanes, back to back.
        got = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge CP); #1;
            A = 32'h6666_666E; INV = 1'b0;
            MODE = 2'(c);
            IN_VLD = (c < 3);
            @(negedge CP);
            if (OUT_VLD && OUT_RDY && got < 3) begin
                chk("mode_per_beat", 32'(Z), 32'(mexp[got]));
                got++;
            end
        end
        chk("mode_beats_seen", 32'(got), 32'd3);
`ifdef GTECH_REDUCE_PIPE_CNT_EN
        chk("cnt_three", 32'(CNT), 32'd3);
`endif

        for (int c = 0; c < 20; c++) begin
            if (sb.size() == 0) break;
            @(negedge CP);
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gtech_reduce_pipe.md
Name: gtech_reduce_pipe

Overview:
- Parametrised, pipelined successor to the fixed 3-input generic AND cell.
- Reduces N lanes of W bits each to one W-bit result, bitwise across lanes. Operation is AND, OR or XOR, with optional inversion (NAND/NOR/XNOR).
- Built as a tree of K-input stages. Each stage has a register and a valid/ready elastic handshake, so it can sit in a streaming datapath with backpressure.

Parameters:
- N, 8, number of input lanes (N >= 2)
- W, 4, width of each lane and of the result (W >= 1)
- K, 3, fan-in per tree stage (K >= 2)
- STAGES, derived ceil(log_K(N)) (8/3 -> 2), pipeline depth (localparam, not overridable)

Ports:
- CP  in  1  clock, rising edge
- CD  in  1  reset, synchronous, active-low
- A  in  N*W  operand lanes; lane i = A[i*W +: W]
- MODE  in  2  00 AND, 01 OR, 10 XOR, 11 AND (alias)
- INV  in  1  invert final result
- IN_VLD  in  1  input beat valid
- IN_RDY  out  1  block can accept a beat
- Z  out  W  reduced result
- OUT_VLD  out  1  Z valid
- OUT_RDY  in  1  downstream accepts Z

Behaviour:
- Single clock CP. Reset CD is synchronous and active-low: sampled on the CP rising edge while low.
- Reset values:
  - all stage valid bits 0, all stage data registers 0;
  - Z = 0, OUT_VLD = 0;
  - IN_RDY = 1 in the first cycle after reset release.
- Transfers:
  - Input transfer occurs when IN_VLD & IN_RDY at a CP edge.
  - Output transfer occurs when OUT_VLD & OUT_RDY.
- Stage structure:
  - Stage s (1..STAGES) holds n_s = ceil(n_{s-1}/K) partial results, with n_0 = N.
  - Group j of stage s combines inputs j*K .. j*K+K-1 of stage s-1.
  - A short last group is padded with the identity element: all-ones for AND, zero for OR/XOR.
- Sideband: MODE and INV are captured with each beat and travel down the pipeline with it. Changing them between beats never affects beats already in flight.
- INV is applied only at the final stage; Z is the registered output of the final stage.
- Advance rule:
  - en_last = !OUT_VLD | OUT_RDY
  - en_s = !vld_s | en_{s+1}
  - IN_RDY = en_1. This is combinational from OUT_RDY; that path is accepted.
- Latency: STAGES cycles from input transfer to OUT_VLD, with no stall. Throughput is 1 beat/cycle while OUT_RDY = 1.
- Stall:
  - While OUT_VLD & !OUT_RDY, Z and OUT_VLD hold stable.
  - Bubbles upstream still collapse.
  - The pipe holds at most STAGES beats before IN_RDY drops.
- Order: beats are never reordered, dropped or duplicated.
- Reset mid-operation: all in-flight beats are discarded. On the next cycle OUT_VLD = 0 and Z = 0.
- Simultaneous input and output transfer in the same cycle with a full pipe: both occur; occupancy is unchanged.
- IN_VLD = 0 or IN_RDY = 0: the A, MODE and INV values are ignored.

Optional Feature:
- Macro: GTECH_REDUCE_PIPE_CNT_EN.
- When defined:
  - Adds output port CNT (16 bits), a count of output transfers.
  - Increments on each OUT_VLD & OUT_RDY and saturates at 16'hFFFF.
  - Reset value 0.
- When undefined: the CNT port and its logic are absent. All other behaviour is identical.

Test Plan (defaults N=8, W=4, K=3, STAGES=2):
1. AND latency: all lanes 4'hF, MODE=00, INV=0, single beat, OUT_RDY=1 -> OUT_VLD high exactly 2 cycles after the transfer, Z=4'hF. Repeat with lane 3=4'hE -> Z=4'hE.
2. XOR and inversion: lanes 0..7 = 1,2,4,8,3,0,0,0 with MODE=10 -> Z=4'hC. Same lanes with INV=1 -> Z=4'h3.
3. Short-group padding:
   - Lanes 0..6 = 0, lane 7 = 4'h5, MODE=01 -> Z=4'h5.
   - Lanes 0..6 = 4'hF, lane 7 = 4'h0, MODE=00 -> Z=4'h0.
   - Lanes 0..7 = 4'hF, MODE=00 -> Z=4'hF (identity padding does not corrupt).
4. Backpressure:
   - Stimulus: IN_VLD=1 with 5 distinct beats while OUT_RDY=0 for 6 cycles -> exactly 2 beats accepted, then IN_RDY=0; Z stable throughout.
   - Release OUT_RDY=1 -> all 5 results emerge in order, one per cycle, with no gaps after the first.
5. Mode per beat: back-to-back beats with MODE 00, 01, 10 on identical lanes -> three results match the respective operations, in order.
6. Reset and counter:
   - CD=0 for one cycle with 2 beats in flight -> next cycle OUT_VLD=0, Z=0, and no stale beat ever appears.
   - With GTECH_REDUCE_PIPE_CNT_EN defined: CNT=0 after reset, CNT=3 after three output transfers.
